r_fwft_output_stage: RTL

Read-side output stage of the asynchronous FIFO, in the r_clk domain, directly downstream of the read-pointer/empty logic and the FIFO memory. It converts the memory's registered read port and the r_empty/r_en interface into a first-word-fall-through valid/ready stream. A 2-entry output buffer keeps full throughput (one word per r_clk) across the one-cycle memory read latency and downstream back-pressure.

---
 rtl/d_ff_async.sv | 18 +
 rtl/r_fwft_output_stage.sv | 103 ++++++++++
 2 files changed

// File: rtl/d_ff_async.sv
// Generic D flip-flop bank with asynchronous active-high reset to zero.
`timescale 1ns/1ps
module d_ff_async #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  // Clear immediately on reset, otherwise load d on the rising clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/r_fwft_output_stage.sv
// Read-side output stage of the async FIFO. It turns the registered memory read
// port into a first-word-fall-through valid/ready stream using a 2-entry buffer
// (head/tail). It issues reads only while buffered plus in-flight words stay
// below two, so an arriving word always has a free slot.
`timescale 1ns/1ps
module r_fwft_output_stage #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 r_clk,
  input  logic                 rrst_n,
  input  logic                 fifo_r_empty,
  output logic                 fifo_r_en,
  input  logic [DATA_SIZE-1:0] fifo_r_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [1:0]           out_count
);

  logic                 rst;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic [1:0]           count_q, count_d;
  logic                 inflight_q, inflight_d;
  logic                 pop;
  logic [2:0]           credit;

  assign rst = ~rrst_n;

  // Credit check: issue a read only if the word will have room on arrival.
  always_comb begin
    pop        = (count_q != 2'd0) & out_ready;
    credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_r_en  = rrst_n & ~fifo_r_empty & (credit < 3'd2);
    inflight_d = fifo_r_en;
  end

  // Buffer update: capture the arriving word into head or tail and shift on pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (inflight_q) begin
      case (count_q)
        2'd0: begin
          head_d  = fifo_r_data;
          count_d = 2'd1;
        end
        2'd1: begin
          if (pop) begin
            head_d = fifo_r_data;
          end else begin
            tail_d  = fifo_r_data;
            count_d = 2'd2;
          end
        end
        default: begin
          // Credit rule keeps this unreachable; if reached, preserve order anyway.
          if (pop) begin
            head_d = tail_q;
            tail_d = fifo_r_data;
          end
        end
      endcase
    end else if (pop) begin
      if (count_q == 2'd2) head_d = tail_q;
      count_d = count_q - 2'd1;
    end
  end

  d_ff_async #(.SIZE(DATA_SIZE)) u_head_ff (
    .clk   (r_clk),
    .reset (rst),
    .d     (head_d),
    .q     (head_q)
  );

  d_ff_async #(.SIZE(DATA_SIZE)) u_tail_ff (
    .clk   (r_clk),
    .reset (rst),
    .d     (tail_d),
    .q     (tail_q)
  );

  d_ff_async #(.SIZE(2)) u_count_ff (
    .clk   (r_clk),
    .reset (rst),
    .d     (count_d),
    .q     (count_q)
  );

  d_ff_async #(.SIZE(1)) u_inflight_ff (
    .clk   (r_clk),
    .reset (rst),
    .d     (inflight_d),
    .q     (inflight_q)
  );

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign out_count = count_q;

endmodule
